// File: rtl/flash_audio_pkg.sv
// Shared types and default widths for the flash audio sequencer.
package flash_audio_pkg;

  localparam int unsigned DEF_ADDR_W   = 23;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_SAMPLE_W = 16;

  // Avalon-MM read port bundle widths
  localparam int unsigned AVM_ADDR_W = DEF_ADDR_W;
  localparam int unsigned AVM_DATA_W = DEF_DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FIRST,
    S_SECOND
  } seq_state_t;

endpackage

// File: rtl/flash_audio_sequencer_stepper.sv
// Next word address for clip playback: forward/reverse walk with wrap,
// and a degenerate clip (end < start) pinned to the start word.
module flash_addr_stepper
  import flash_audio_pkg::*;
#(
  parameter int unsigned ADDR_W = AVM_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              direction,
  output logic [ADDR_W-1:0] next_addr
);

  always_comb begin
    next_addr = addr + ADDR_W'(1);
    if (end_addr < start_addr) begin
      next_addr = start_addr;
    end else if (direction) begin
      if (addr >= end_addr) next_addr = start_addr;
    end else if (addr <= start_addr) begin
      next_addr = end_addr;
    end else begin
      next_addr = addr - ADDR_W'(1);
    end
  end

endmodule

// File: rtl/flash_audio_sequencer.sv
// Fetches 32-bit words from flash over Avalon-MM and presents them as two
// 16-bit samples, one per sample_tick, with pause/restart/underrun handling.
module flash_audio_sequencer
  import flash_audio_pkg::*;
#(
  parameter int unsigned ADDR_W   = AVM_ADDR_W,
  parameter int unsigned DATA_W   = AVM_DATA_W,
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_tick,
  input  logic [ADDR_W-1:0]   start_address,
  input  logic [ADDR_W-1:0]   end_address,
  input  logic                direction,
  input  logic                pause,
  input  logic                restart,
  output logic                flash_mem_read,
  output logic [ADDR_W-1:0]   flash_mem_address,
  input  logic                flash_mem_waitrequest,
  input  logic [DATA_W-1:0]   flash_mem_readdata,
  input  logic                flash_mem_readdatavalid,
  output logic [SAMPLE_W-1:0] audio_data,
  output logic                audio_valid,
  output logic                underrun,
  output logic                playing
);

  seq_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, step_addr, load_addr;
  logic [DATA_W-1:0]   word_q, word_d;
  logic                word_fwd_q, word_fwd_d;
  logic                pending_q, pending_d;
  logic [SAMPLE_W-1:0] audio_data_d, lo_half, hi_half;
  logic                audio_valid_d, underrun_d, tick_ok;

  assign tick_ok           = sample_tick & ~pause;
  assign lo_half           = word_q[SAMPLE_W-1:0];
  assign hi_half           = word_q[DATA_W-1:SAMPLE_W];
  assign flash_mem_address = addr_q;

  // Reverse playback begins at the clip end unless the clip is degenerate
  assign load_addr = (~direction && (end_address >= start_address)) ? end_address
                                                                    : start_address;

  flash_addr_stepper #(.ADDR_W(ADDR_W)) u_stepper (
    .addr       (addr_q),
    .start_addr (start_address),
    .end_addr   (end_address),
    .direction  (direction),
    .next_addr  (step_addr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      word_q         <= '0;
      word_fwd_q     <= 1'b0;
      pending_q      <= 1'b0;
      flash_mem_read <= 1'b0;
      audio_data     <= '0;
      audio_valid    <= 1'b0;
      underrun       <= 1'b0;
      playing        <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      word_q         <= word_d;
      word_fwd_q     <= word_fwd_d;
      pending_q      <= pending_d;
      flash_mem_read <= (state_d == S_REQ);
      audio_data     <= audio_data_d;
      audio_valid    <= audio_valid_d;
      underrun       <= underrun_d;
      playing        <= ~pause & (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    word_d        = word_q;
    word_fwd_d    = word_fwd_q;
    pending_d     = pending_q;
    audio_data_d  = audio_data;
    audio_valid_d = 1'b0;
    underrun_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        addr_d    = load_addr;
        pending_d = 1'b0;
        if (!restart && !pause) state_d = S_REQ;
      end
      S_REQ: begin
        underrun_d = tick_ok;
        if (restart) pending_d = 1'b1;
        if (!flash_mem_waitrequest) state_d = S_WAIT;
      end
      S_WAIT: begin
        underrun_d = tick_ok;
        if (restart) pending_d = 1'b1;
        // A restarted fetch still drains its data beat, then drops it
        if (flash_mem_readdatavalid) begin
          if (pending_q || restart) begin
            pending_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            word_d     = flash_mem_readdata;
            word_fwd_d = direction;
            state_d    = S_FIRST;
          end
        end
      end
      S_FIRST: begin
        if (restart) begin
          state_d = S_IDLE;
        end else if (tick_ok) begin
          audio_data_d  = word_fwd_q ? lo_half : hi_half;
          audio_valid_d = 1'b1;
          state_d       = S_SECOND;
        end
      end
      S_SECOND: begin
        if (restart) begin
          state_d = S_IDLE;
        end else if (tick_ok) begin
          audio_data_d  = word_fwd_q ? hi_half : lo_half;
          audio_valid_d = 1'b1;
          addr_d        = step_addr;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
